// File: rtl/nanov_alu_arbiter_if.sv
// rtl/nanov_alu_arbiter_if.sv - request/response handshake bundle for the two ALU arbiter ports
interface nanov_alu_arbiter_if;
    logic        req_valid_0;
    logic        req_ready_0;
    logic [2:0]  req_op_0;
    logic [31:0] req_a_0;
    logic [31:0] req_b_0;
    logic        resp_valid_0;
    logic        resp_ready_0;
    logic [31:0] resp_d_0;

    logic        req_valid_1;
    logic        req_ready_1;
    logic [2:0]  req_op_1;
    logic [31:0] req_a_1;
    logic [31:0] req_b_1;
    logic        resp_valid_1;
    logic        resp_ready_1;
    logic [31:0] resp_d_1;

    modport master (
        output req_valid_0, req_op_0, req_a_0, req_b_0, resp_ready_0,
        output req_valid_1, req_op_1, req_a_1, req_b_1, resp_ready_1,
        input  req_ready_0, resp_valid_0, resp_d_0,
        input  req_ready_1, resp_valid_1, resp_d_1
    );

    modport slave (
        input  req_valid_0, req_op_0, req_a_0, req_b_0, resp_ready_0,
        input  req_valid_1, req_op_1, req_a_1, req_b_1, resp_ready_1,
        output req_ready_0, resp_valid_0, resp_d_0,
        output req_ready_1, resp_valid_1, resp_d_1
    );
endinterface

// File: rtl/nanov_alu_arbiter.sv
// rtl/nanov_alu_arbiter.sv - one shared ALU arbitrated between two buffered requesters
// Define NANOV_ALU_ARB_RR_EN for round-robin contention; otherwise port 0 has fixed priority.
module nanov_alu_arbiter (
    input  logic                 clk,
    input  logic                 rstn,
    nanov_alu_arbiter_if.slave   bus
);
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [1:0]  resp_ready;
    logic [1:0]  accept;
    logic [1:0]  elig;
    logic [1:0]  issue;
    logic [1:0]  h_full;
    logic [1:0]  r_full;
    logic [2:0]  in_op [2];
    logic [31:0] in_a  [2];
    logic [31:0] in_b  [2];
    logic [2:0]  h_op  [2];
    logic [31:0] h_a   [2];
    logic [31:0] h_b   [2];
    logic [31:0] r_d   [2];

    assign req_valid  = {bus.req_valid_1, bus.req_valid_0};
    assign resp_ready = {bus.resp_ready_1, bus.resp_ready_0};
    assign in_op[0]   = bus.req_op_0;
    assign in_op[1]   = bus.req_op_1;
    assign in_a[0]    = bus.req_a_0;
    assign in_a[1]    = bus.req_a_1;
    assign in_b[0]    = bus.req_b_0;
    assign in_b[1]    = bus.req_b_1;

    assign bus.req_ready_0  = req_ready[0];
    assign bus.req_ready_1  = req_ready[1];
    assign bus.resp_valid_0 = r_full[0];
    assign bus.resp_valid_1 = r_full[1];
    assign bus.resp_d_0     = r_d[0];
    assign bus.resp_d_1     = r_d[1];

    // A port may issue only if its response slot is empty or is being drained this cycle.
    assign elig      = h_full & (~r_full | resp_ready);
    assign req_ready = ~h_full | issue;
    assign accept    = req_valid & req_ready;

`ifdef NANOV_ALU_ARB_RR_EN
    logic last;

    always_comb begin
        issue = elig;
        if (elig == 2'b11) begin
            issue = last ? 2'b01 : 2'b10;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            last <= 1'b1;
        end else if (|issue) begin
            last <= issue[1];
        end
    end
`else
    assign issue = {elig[1] & ~elig[0], elig[0]};
`endif

    logic        sel;
    logic [2:0]  alu_op;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [31:0] alu_d;

    assign sel    = issue[1];
    assign alu_op = h_op[sel];
    assign alu_a  = h_a[sel];
    assign alu_b  = h_b[sel];

    // Ops 001 and 101 have no function and quietly produce zero.
    always_comb begin
        alu_d = 32'h0;
        case (alu_op)
            3'b000:  alu_d = alu_a + alu_b;
            3'b010:  alu_d = {31'h0, $signed(alu_a) < $signed(alu_b)};
            3'b011:  alu_d = {31'h0, alu_a < alu_b};
            3'b100:  alu_d = alu_a ^ alu_b;
            3'b110:  alu_d = alu_a | alu_b;
            3'b111:  alu_d = alu_a & alu_b;
            default: alu_d = 32'h0;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            h_full <= 2'b00;
            r_full <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                h_op[i] <= 3'h0;
                h_a[i]  <= 32'h0;
                h_b[i]  <= 32'h0;
                r_d[i]  <= 32'h0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (accept[i]) begin
                    h_full[i] <= 1'b1;
                    h_op[i]   <= in_op[i];
                    h_a[i]    <= in_a[i];
                    h_b[i]    <= in_b[i];
                end else if (issue[i]) begin
                    h_full[i] <= 1'b0;
                end

                if (issue[i]) begin
                    r_full[i] <= 1'b1;
                    r_d[i]    <= alu_d;
                end else if (resp_ready[i]) begin
                    r_full[i] <= 1'b0;
                end
            end
        end
    end
endmodule
